mc_controller: RTL
==================

# mc_controller

Multi-cycle control unit for the RV32I core, with optional M-extension sequencing. It replaces the single-cycle opcode decoder with an FSM that fetches over a req/ack instruction port, decodes a latched instruction register, waits on data memory and a fixed-latency mul/div unit, and pulses the write-enables for PC, IR and the register file. It sits between the instruction/data memory interfaces and the datapath.

## Interface
Parameters:
- ENABLE_M, 1: 1 decodes funct7=0000001 on opcode 0110011 as mul/div; 0 makes those encodings illegal.
- MULDIV_CYCLES, 4: cycles spent in MDWAIT; legal range 1..15.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req  out  1  instruction fetch request.
- imem_ack  in  1  fetch complete; instr valid this cycle.
- instr  in  32  fetched instruction.
- dmem_req  out  1  data access request.
- dmem_we  out  1  1 = store, 0 = load; valid with dmem_req.
- dmem_ack  in  1  data access complete.
- ir_we  out  1  latch instr into IR (pulse).
- pc_we  out  1  commit next PC (pulse).
- reg_write  out  1  register-file write (pulse).
- md_start  out  1  start mul/div unit (pulse).
- alu_src  out  5  one-hot: [0] R/muldiv, [1] I/load, [2] store, [3] lui, [4] auipc.
- mem_to_reg  out  3  one-hot: [0] ALU/muldiv, [1] load, [2] PC+4 for jal/jalr.
- alu_control  out  7  {muldiv, auipc, lui, sw, lw, I, R}.
- branch_control  out  3  {jal, jalr, B}.
- illegal  out  1  high while in TRAP.
- state  out  3  current FSM state, for debug.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, MDWAIT, WB, TRAP. Encodings live in the package.
- IDLE: always moves to FETCH on the next cycle.
- FETCH: imem_req=1. On imem_ack, ir_we=1, instr is latched and the next state is DECODE. Otherwise stay in FETCH.
- DECODE: mc_decode classifies IR. Illegal opcode, or muldiv with ENABLE_M=0, goes to TRAP. Everything else goes to EXEC.
- EXEC, by class:
  - R, I, lui, auipc, jal, jalr: go to WB.
  - load or store: go to MEM.
  - B-type: pc_we=1 and go to FETCH.
  - muldiv: md_start=1, counter is loaded with MULDIV_CYCLES, go to MDWAIT.
- MEM: dmem_req=1 and dmem_we=sw. On dmem_ack, a load goes to WB, and a store asserts pc_we=1 and goes to FETCH.
- MDWAIT: counter decrements each cycle. When the counter is 1, go to WB.
- WB: reg_write=1, pc_we=1, then go to FETCH.
- TRAP: illegal=1. TRAP is terminal; only rst exits it.
- Decode outputs (alu_src, mem_to_reg, alu_control, branch_control) are driven from IR only in states DECODE through WB; they are 0 in IDLE, FETCH and TRAP. At most one bit of each is set.
- imem_ack outside FETCH and dmem_ack outside MEM are ignored.

## Timing
- Reset value of every output is 0; state is IDLE. Reset clears IR and the counter.
- Reset asserted mid-operation: all outputs go to 0 asynchronously; an in-flight req is dropped and a late ack is ignored.
- Request outputs and pulse outputs are combinational from state and ack, so single-cycle ack works.
- Instruction latency with zero-wait memories (ack in the same cycle as req):
  - R / I / lui / auipc / jal / jalr: 4 cycles (FETCH, DECODE, EXEC, WB).
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch: 3 cycles.
  - muldiv: 4 + MULDIV_CYCLES cycles.
- Each memory wait cycle adds exactly 1 cycle.
- pc_we is asserted exactly once per retired instruction; ir_we exactly once per fetch.
- Counter width is 4 bits; it never wraps, since it is reloaded only in EXEC.

## Structure
- Package riscv_ctrl_pkg holds:
  - opcode constants: 0110011, 0010011, 0000011, 0100011, 1100011, 1100111, 1101111, 0110111, 0010111;
  - the MULDIV funct7 constant;
  - the state enum;
  - bit-index constants for the one-hot control buses.
- Sub-module mc_decode: purely combinational decode of IR to class one-hots and an illegal flag. It is the successor to the single-cycle decoder.
- mc_controller holds the FSM, IR, counter and output gating.

## Test plan
- ADD 0x002081B3 with zero-wait memories: states FETCH→DECODE→EXEC→WB, with reg_write=1, pc_we=1 in cycle 4. In EXEC, alu_src=00001 and alu_control=0000001.
- LW with dmem_ack held low for 3 cycles: MEM lasts 4 cycles with dmem_req=1 and dmem_we=0. Then WB with mem_to_reg=010; total latency 8 cycles.
- MUL 0x022081B3, ENABLE_M=1, MULDIV_CYCLES=4: md_start is pulsed in EXEC, MDWAIT lasts 4 cycles, reg_write occurs at cycle 8. With ENABLE_M=0, the same instruction reaches TRAP with illegal=1 held.
- BEQ: branch_control=001 in EXEC, and pc_we is pulsed in EXEC (cycle 3). reg_write stays 0 throughout.
- Assert rst during MEM with dmem_req=1, then send dmem_ack after release: outputs are 0 immediately, the state is IDLE then FETCH, the stale ack is ignored, and no pc_we occurs.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared constants, state encoding and decode payload for the multi-cycle RV32I control unit.
package riscv_ctrl_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 4;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    MDWAIT = 3'd5,
    WB     = 3'd6,
    TRAP   = 3'd7
  } state_e;

  // alu_src bit indices
  localparam int unsigned AS_W     = 5;
  localparam int unsigned AS_R     = 0;
  localparam int unsigned AS_I     = 1;
  localparam int unsigned AS_S     = 2;
  localparam int unsigned AS_LUI   = 3;
  localparam int unsigned AS_AUIPC = 4;

  // mem_to_reg bit indices
  localparam int unsigned MR_W    = 3;
  localparam int unsigned MR_ALU  = 0;
  localparam int unsigned MR_LOAD = 1;
  localparam int unsigned MR_PC4  = 2;

  // alu_control bit indices
  localparam int unsigned AC_W     = 7;
  localparam int unsigned AC_R     = 0;
  localparam int unsigned AC_I     = 1;
  localparam int unsigned AC_LW    = 2;
  localparam int unsigned AC_SW    = 3;
  localparam int unsigned AC_LUI   = 4;
  localparam int unsigned AC_AUIPC = 5;
  localparam int unsigned AC_MD    = 6;

  // branch_control bit indices
  localparam int unsigned BC_W    = 3;
  localparam int unsigned BC_B    = 0;
  localparam int unsigned BC_JALR = 1;
  localparam int unsigned BC_JAL  = 2;

  typedef struct packed {
    logic r;
    logic i;
    logic load;
    logic store;
    logic branch;
    logic jalr;
    logic jal;
    logic lui;
    logic auipc;
    logic muldiv;
  } iclass_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction classifier: one-hot class plus an illegal flag.
module mc_decode
  import riscv_ctrl_pkg::*;
#(
  parameter bit ENABLE_M = 1'b1
) (
  input  logic [XLEN-1:0] ir,
  output iclass_t         cls_c,
  output logic            illegal_c
);

  logic [6:0] opcode;
  logic [6:0] funct7;
  logic       unused_ir_bits;

  assign opcode         = ir[6:0];
  assign funct7         = ir[31:25];
  assign unused_ir_bits = ^ir[24:7];

  always_comb begin
    cls_c     = '0;
    illegal_c = 1'b0;
    case (opcode)
      OP_R: begin
        // mul/div encodings are only legal when the M extension is built in
        if (funct7 == F7_MULDIV) begin
          if (ENABLE_M) cls_c.muldiv = 1'b1;
          else          illegal_c    = 1'b1;
        end else begin
          cls_c.r = 1'b1;
        end
      end
      OP_I:      cls_c.i      = 1'b1;
      OP_LOAD:   cls_c.load   = 1'b1;
      OP_STORE:  cls_c.store  = 1'b1;
      OP_BRANCH: cls_c.branch = 1'b1;
      OP_JALR:   cls_c.jalr   = 1'b1;
      OP_JAL:    cls_c.jal    = 1'b1;
      OP_LUI:    cls_c.lui    = 1'b1;
      OP_AUIPC:  cls_c.auipc  = 1'b1;
      default:   illegal_c    = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle RV32I control FSM: fetch over req/ack, decode IR, sequence memory and mul/div waits.
module mc_controller
  import riscv_ctrl_pkg::*;
#(
  parameter bit          ENABLE_M      = 1'b1,
  parameter int unsigned MULDIV_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  input  logic             imem_ack,
  input  logic [XLEN-1:0]  instr,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ack,
  output logic             ir_we,
  output logic             pc_we,
  output logic             reg_write,
  output logic             md_start,
  output logic [AS_W-1:0]  alu_src,
  output logic [MR_W-1:0]  mem_to_reg,
  output logic [AC_W-1:0]  alu_control,
  output logic [BC_W-1:0]  branch_control,
  output logic             illegal,
  output logic [2:0]       state
);

  state_e           state_q, state_d;
  logic [XLEN-1:0]  ir_q, ir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  iclass_t          cls;
  logic             dec_illegal;
  logic             dec_active;

  mc_decode #(.ENABLE_M(ENABLE_M)) u_decode (
    .ir        (ir_q),
    .cls_c     (cls),
    .illegal_c (dec_illegal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ir_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state plus request/pulse outputs, combinational from state and acks
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    cnt_d     = cnt_q;
    imem_req  = 1'b0;
    ir_we     = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    pc_we     = 1'b0;
    reg_write = 1'b0;
    md_start  = 1'b0;
    illegal   = 1'b0;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_we   = 1'b1;
          ir_d    = instr;
          state_d = DECODE;
        end
      end
      DECODE: state_d = dec_illegal ? TRAP : EXEC;
      EXEC: begin
        if (cls.load || cls.store) begin
          state_d = MEM;
        end else if (cls.branch) begin
          pc_we   = 1'b1;
          state_d = FETCH;
        end else if (cls.muldiv) begin
          md_start = 1'b1;
          cnt_d    = CNT_W'(MULDIV_CYCLES);
          state_d  = MDWAIT;
        end else begin
          state_d = WB;
        end
      end
      MEM: begin
        dmem_req = 1'b1;
        dmem_we  = cls.store;
        if (dmem_ack) begin
          if (cls.store) begin
            pc_we   = 1'b1;
            state_d = FETCH;
          end else begin
            state_d = WB;
          end
        end
      end
      MDWAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = WB;
      end
      WB: begin
        reg_write = 1'b1;
        pc_we     = 1'b1;
        state_d   = FETCH;
      end
      TRAP:    illegal = 1'b1;
      default: state_d = IDLE;
    endcase
  end

  assign dec_active = (state_q inside {DECODE, EXEC, MEM, MDWAIT, WB});

  // Datapath steering from the latched IR, quiet outside the decode window
  always_comb begin
    alu_src        = '0;
    mem_to_reg     = '0;
    alu_control    = '0;
    branch_control = '0;
    if (dec_active) begin
      alu_src[AS_R]        = cls.r | cls.muldiv;
      alu_src[AS_I]        = cls.i | cls.load;
      alu_src[AS_S]        = cls.store;
      alu_src[AS_LUI]      = cls.lui;
      alu_src[AS_AUIPC]    = cls.auipc;
      mem_to_reg[MR_ALU]   = cls.r | cls.i | cls.lui | cls.auipc | cls.muldiv;
      mem_to_reg[MR_LOAD]  = cls.load;
      mem_to_reg[MR_PC4]   = cls.jal | cls.jalr;
      alu_control[AC_R]    = cls.r;
      alu_control[AC_I]    = cls.i;
      alu_control[AC_LW]   = cls.load;
      alu_control[AC_SW]   = cls.store;
      alu_control[AC_LUI]  = cls.lui;
      alu_control[AC_AUIPC]= cls.auipc;
      alu_control[AC_MD]   = cls.muldiv;
      branch_control[BC_B]    = cls.branch;
      branch_control[BC_JALR] = cls.jalr;
      branch_control[BC_JAL]  = cls.jal;
    end
  end

  assign state = state_q;

endmodule
